fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 118 +++++++++++
 tb/tb_fetch_unit.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch front end: credit-limited request issue, a 2-deep {instr, pc} queue
// to decode, and redirect handling that drains stale in-flight responses.
module fetch_unit #(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [XLEN-1:0] instr_pc_plus_4
);
    typedef enum logic [1:0] {BOOT, RUN, FLUSH} state_t;

    state_t                 state, state_nxt;
    logic [XLEN-1:0]        pc, pc_nxt;
    logic [1:0]             outstanding, out_nxt;
    logic [1:0]             drop, drop_nxt;
    logic [1:0]             count, count_nxt;
    logic                   wr_ptr, wr_ptr_nxt, rd_ptr, rd_ptr_nxt;
    logic [1:0][31:0]       fifo_instr;
    logic [1:0][XLEN-1:0]   fifo_pc;
    logic                   fire, deq, enq, rsp_dec;
    logic [2:0]             credit;
    logic [XLEN-1:0]        rsp_pc, redirect_aligned;

    assign credit           = {1'b0, outstanding} + {1'b0, count};
    assign imem_req_valid   = (state == RUN) && !redirect_valid && (credit < 3'd2);
    assign imem_req_addr    = pc;
    assign fire             = imem_req_valid & imem_req_ready;
    assign deq              = instr_valid & instr_ready;
    // A response that counts against a live request; one arriving with nothing in flight is ignored.
    assign rsp_dec          = imem_rsp_valid && (outstanding != 2'd0);
    assign redirect_aligned = redirect_pc & ~XLEN'(3);
    // With no drops pending, every in-flight request belongs to the current stream,
    // so the oldest one was issued outstanding*4 bytes behind the fetch PC.
    assign rsp_pc           = pc - XLEN'({outstanding, 2'b00});

    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc;
        out_nxt    = outstanding;
        drop_nxt   = drop;
        count_nxt  = count;
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        enq        = 1'b0;
        case (state)
            BOOT: begin
                state_nxt = RUN;
                if (redirect_valid) pc_nxt = redirect_aligned;
            end
            default: begin
                if (redirect_valid) begin
                    pc_nxt     = redirect_aligned;
                    count_nxt  = 2'd0;
                    wr_ptr_nxt = 1'b0;
                    rd_ptr_nxt = 1'b0;
                    out_nxt    = outstanding - 2'(rsp_dec);
                    drop_nxt   = outstanding - 2'(rsp_dec);
                    state_nxt  = (out_nxt != 2'd0) ? FLUSH : RUN;
                end else begin
                    if (fire) pc_nxt = pc + XLEN'(4);
                    if (rsp_dec) begin
                        if (drop != 2'd0) drop_nxt = drop - 2'd1;
                        else              enq      = 1'b1;
                    end
                    out_nxt = outstanding + 2'(fire) - 2'(rsp_dec);
                    if (enq) wr_ptr_nxt = ~wr_ptr;
                    if (deq) rd_ptr_nxt = ~rd_ptr;
                    count_nxt = count + 2'(enq) - 2'(deq);
                    if (state == FLUSH && drop == 2'd0) state_nxt = RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            outstanding <= 2'd0;
            drop        <= 2'd0;
            count       <= 2'd0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            fifo_instr  <= '0;
            fifo_pc     <= '0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            outstanding <= out_nxt;
            drop        <= drop_nxt;
            count       <= count_nxt;
            wr_ptr      <= wr_ptr_nxt;
            rd_ptr      <= rd_ptr_nxt;
            if (enq) begin
                fifo_instr[wr_ptr] <= imem_rsp_data;
                fifo_pc[wr_ptr]    <= rsp_pc;
            end
        end
    end

    // Head outputs are gated so decode sees zeros whenever the queue is empty.
    assign instr_valid     = (count != 2'd0);
    assign instr           = instr_valid ? fifo_instr[rd_ptr] : 32'd0;
    assign instr_pc        = instr_valid ? fifo_pc[rd_ptr] : '0;
    assign instr_pc_plus_4 = instr_valid ? fifo_pc[rd_ptr] + XLEN'(4) : '0;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a per-cycle vector table for the straight-line fetch
// stream, then hand-written sequences for backpressure, redirect, wrap and reset cases.
module tb_fetch_unit;
    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            imem_req_valid, imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [31:0]     imem_rsp_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            instr_valid, instr_ready;
    logic [31:0]     instr;
    logic [XLEN-1:0] instr_pc, instr_pc_plus_4;

    fetch_unit #(.XLEN(XLEN), .RESET_PC(64'h0)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .instr_pc(instr_pc), .instr_pc_plus_4(instr_pc_plus_4)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [XLEN-1:0] a);
        return a[31:0] ^ 32'hC0DE_0013;
    endfunction

    // Memory model: auto mode answers every accepted request one cycle later.
    logic            auto_mem = 1'b1;
    logic            man_rsp_valid = 1'b0;
    logic [31:0]     man_rsp_data = 32'd0;
    logic            fired_q;
    logic [XLEN-1:0] fired_addr;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fired_q    <= 1'b0;
            fired_addr <= '0;
        end else begin
            fired_q    <= imem_req_valid & imem_req_ready;
            fired_addr <= imem_req_addr;
        end
    end
    assign imem_rsp_valid = auto_mem ? fired_q : man_rsp_valid;
    assign imem_rsp_data  = auto_mem ? word_of(fired_addr) : man_rsp_data;

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        man_rsp_valid  = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    typedef struct {
        logic            irdy;
        logic            exp_rv;
        logic [XLEN-1:0] exp_addr;
        logic            exp_iv;
        logic [XLEN-1:0] exp_pc;
    } vec_t;

    vec_t tbl[7];

    initial begin
        // Row k is observed after the k-th rising edge following reset release.
        tbl[0] = '{1'b1, 1'b0, 64'h0, 1'b0, 64'h0};
        tbl[1] = '{1'b1, 1'b1, 64'h0, 1'b0, 64'h0};
        tbl[2] = '{1'b1, 1'b1, 64'h4, 1'b0, 64'h0};
        tbl[3] = '{1'b1, 1'b0, 64'h0, 1'b1, 64'h0};
        tbl[4] = '{1'b1, 1'b1, 64'h8, 1'b1, 64'h4};
        tbl[5] = '{1'b1, 1'b1, 64'hC, 1'b0, 64'h0};
        tbl[6] = '{1'b1, 1'b0, 64'h0, 1'b1, 64'h8};

        imem_req_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        instr_ready    = 1'b1;
        #1;
        chk("reset_req_valid", imem_req_valid, 0);
        chk("reset_instr_valid", instr_valid, 0);
        chk("reset_instr", instr, 0);
        chk("reset_instr_pc", instr_pc, 0);

        // Straight-line stream, 1-cycle memory
        auto_mem = 1'b1;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            instr_ready = tbl[i].irdy;
            #1;
            chk($sformatf("vec%0d_req_valid", i), imem_req_valid, tbl[i].exp_rv);
            if (tbl[i].exp_rv) chk($sformatf("vec%0d_addr", i), imem_req_addr, tbl[i].exp_addr);
            chk($sformatf("vec%0d_instr_valid", i), instr_valid, tbl[i].exp_iv);
            if (tbl[i].exp_iv) begin
                chk($sformatf("vec%0d_pc", i), instr_pc, tbl[i].exp_pc);
                chk($sformatf("vec%0d_pc4", i), instr_pc_plus_4, tbl[i].exp_pc + 64'd4);
                chk($sformatf("vec%0d_instr", i), instr, word_of(tbl[i].exp_pc));
            end
            tick();
        end

        // Decoder stalled with two entries queued
        auto_mem = 1'b1;
        instr_ready = 1'b0;
        do_reset();
        repeat (8) tick();
        chk("stall_req_valid", imem_req_valid, 0);
        chk("stall_head_pc", instr_pc, 64'h0);
        chk("stall_head_instr", instr, word_of(64'h0));
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        #1;
        chk("stall_resume_req", imem_req_valid, 1);
        chk("stall_resume_addr", imem_req_addr, 64'h8);
        chk("stall_second_pc", instr_pc, 64'h4);
        chk("stall_second_instr", instr, word_of(64'h4));
        instr_ready = 1'b1;
        tick();
        tick();
        chk("stall_third_valid", instr_valid, 1);
        chk("stall_third_pc", instr_pc, 64'h8);

        // Redirect with two outstanding: both responses dropped
        auto_mem = 1'b0;
        instr_ready = 1'b1;
        do_reset();
        repeat (3) tick();
        chk("redir2_credit_full", imem_req_valid, 0);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h1002;
        #1;
        chk("redir2_no_req", imem_req_valid, 0);
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("redir2_flush_no_req", imem_req_valid, 0);
        man_rsp_valid = 1'b1;
        man_rsp_data  = 32'hBAD0_0001;
        tick();
        chk("redir2_drop1", instr_valid, 0);
        tick();
        man_rsp_valid = 1'b0;
        #1;
        chk("redir2_drop2", instr_valid, 0);
        chk("redir2_still_flush", imem_req_valid, 0);
        tick();
        chk("redir2_run_req", imem_req_valid, 1);
        chk("redir2_addr", imem_req_addr, 64'h1000);
        tick();
        man_rsp_valid = 1'b1;
        man_rsp_data  = 32'h0000_1013;
        tick();
        man_rsp_valid = 1'b0;
        #1;
        chk("redir2_first_valid", instr_valid, 1);
        chk("redir2_first_pc", instr_pc, 64'h1000);
        chk("redir2_first_instr", instr, 32'h0000_1013);

        // Redirect coinciding with a response and a dequeue
        auto_mem = 1'b0;
        instr_ready = 1'b0;
        do_reset();
        repeat (2) tick();
        man_rsp_valid = 1'b1;
        man_rsp_data  = 32'h0000_0A13;
        tick();
        man_rsp_valid = 1'b0;
        #1;
        chk("coll_queued_pc", instr_pc, 64'h0);
        chk("coll_credit_full", imem_req_valid, 0);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h2000;
        man_rsp_valid  = 1'b1;
        man_rsp_data   = 32'hBAD0_0002;
        instr_ready    = 1'b1;
        tick();
        redirect_valid = 1'b0;
        man_rsp_valid  = 1'b0;
        instr_ready    = 1'b0;
        #1;
        chk("coll_fifo_empty", instr_valid, 0);
        chk("coll_no_flush_req", imem_req_valid, 1);
        chk("coll_addr", imem_req_addr, 64'h2000);
        tick();
        man_rsp_valid = 1'b1;
        man_rsp_data  = 32'h0000_2013;
        tick();
        man_rsp_valid = 1'b0;
        #1;
        chk("coll_next_valid", instr_valid, 1);
        chk("coll_next_pc", instr_pc, 64'h2000);
        chk("coll_next_instr", instr, 32'h0000_2013);

        // PC wrap at the top of the address space
        auto_mem = 1'b1;
        instr_ready = 1'b0;
        do_reset();
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        chk("wrap_redirect_no_req", imem_req_valid, 0);
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("wrap_addr_top", imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        tick();
        chk("wrap_req_valid", imem_req_valid, 1);
        chk("wrap_addr_zero", imem_req_addr, 64'h0);
        tick();
        chk("wrap_instr_pc", instr_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap_pc4", instr_pc_plus_4, 64'h0);
        chk("wrap_instr", instr, word_of(64'hFFFF_FFFF_FFFF_FFFC));

        // Stray response with nothing in flight, and address hold under backpressure
        auto_mem = 1'b0;
        instr_ready = 1'b1;
        do_reset();
        imem_req_ready = 1'b0;
        tick();
        chk("stray_addr0", imem_req_addr, 64'h0);
        man_rsp_valid = 1'b1;
        man_rsp_data  = 32'hBAD0_0003;
        tick();
        man_rsp_valid = 1'b0;
        #1;
        chk("stray_discarded", instr_valid, 0);
        chk("hold_req_valid", imem_req_valid, 1);
        chk("hold_addr", imem_req_addr, 64'h0);
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        #1;
        chk("stray_no_underflow", imem_req_valid, 1);
        chk("stray_next_addr", imem_req_addr, 64'h4);
        man_rsp_valid = 1'b1;
        man_rsp_data  = 32'h0000_0013;
        tick();
        man_rsp_valid = 1'b0;
        #1;
        chk("stray_real_pc", instr_pc, 64'h0);
        chk("stray_real_instr", instr, 32'h0000_0013);

        // Reset while flushing with one request in flight
        auto_mem = 1'b0;
        instr_ready = 1'b1;
        imem_req_ready = 1'b1;
        do_reset();
        repeat (2) tick();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h3000;
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("flush_rst_pre_req", imem_req_valid, 0);
        rst_n = 1'b0;
        #1;
        chk("flush_rst_req_valid", imem_req_valid, 0);
        chk("flush_rst_instr_valid", instr_valid, 0);
        chk("flush_rst_instr", instr, 0);
        chk("flush_rst_pc", instr_pc, 0);
        chk("flush_rst_pc4", instr_pc_plus_4, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        tick();
        chk("flush_rst_req_after", imem_req_valid, 1);
        chk("flush_rst_addr_after", imem_req_addr, 64'h0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
